// File: rtl/gate_unit_pipe.sv
// rtl/gate_unit_pipe.sv - registered WIDTH-bit gate unit with valid/ready handshakes
module gate_unit_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             parity,
  output logic             illegal,
  output logic             err_sticky,
  input  logic             err_clr,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NAND = 3'd2,
    OP_NOR  = 3'd3,
    OP_XOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_NOT  = 3'd6,
    OP_ILL  = 3'd7
  } op_e;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_y;
  logic             r_parity;
  logic             r_illegal;
  logic             r_err_sticky;
  logic [CNT_W-1:0] r_op_count;

  logic             w_in_ready;
  logic             w_accept;
  logic [WIDTH-1:0] w_result;
  logic             w_illegal;

  // The single result slot frees up in the same cycle the consumer takes it,
  // so streaming runs at one result per cycle without a bubble.
  assign w_in_ready = !r_out_valid || out_ready;
  assign w_accept   = in_valid && w_in_ready;

  // Gate function select; opcode 7 (and any unknown opcode) yields zero and flags illegal.
  always_comb begin
    w_result  = '0;
    w_illegal = 1'b0;
    case (op)
      OP_AND:  w_result = a & b;
      OP_OR:   w_result = a | b;
      OP_NAND: w_result = ~(a & b);
      OP_NOR:  w_result = ~(a | b);
      OP_XOR:  w_result = a ^ b;
      OP_XNOR: w_result = ~(a ^ b);
      OP_NOT:  w_result = ~a;
      default: w_illegal = 1'b1;
    endcase
  end

  // Result register: load on accept, otherwise drop valid once the consumer takes it.
  // y/parity/illegal only change on accept, so they hold under backpressure and after drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_y         <= '0;
      r_parity    <= 1'b0;
      r_illegal   <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_y         <= w_result;
      r_parity    <= ^w_result;
      r_illegal   <= w_illegal;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Accepted-operation counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_count <= '0;
    end else if (w_accept) begin
      r_op_count <= r_op_count + CNT_W'(1);
    end
  end

  // Sticky error: an accepted illegal opcode takes priority over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_sticky <= 1'b0;
    end else if (w_accept && w_illegal) begin
      r_err_sticky <= 1'b1;
    end else if (err_clr) begin
      r_err_sticky <= 1'b0;
    end
  end

  assign in_ready   = w_in_ready;
  assign out_valid  = r_out_valid;
  assign y          = r_y;
  assign parity     = r_parity;
  assign illegal    = r_illegal;
  assign err_sticky = r_err_sticky;
  assign op_count   = r_op_count;

endmodule

// File: doc/gate_unit_pipe.md
Name: gate_unit_pipe

Overview:
- Parametrised, registered successor to the 2-input NAND primitive: a WIDTH-bit bitwise logic unit with a selectable gate function (AND/OR/NAND/NOR/XOR/XNOR/NOT).
- Operands enter through a valid/ready handshake; results are held in an output register with their own valid/ready handshake.
- Also provides result parity, a per-result illegal-opcode flag, a sticky error flag and a count of accepted operations.
- Sits between operand producers and downstream consumers in the gate-level datapath experiments.

Parameters:
- WIDTH, 8, operand/result bit width (>=1)
- CNT_W, 16, width of accepted-operation counter

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand/opcode presented
- in_ready  output  1  unit can accept this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B (ignored for NOT)
- op  input  3  function select
- out_valid  output  1  result register holds a result
- out_ready  input  1  consumer accepts result
- y  output  WIDTH  registered result
- parity  output  1  XOR-reduction of y, registered with y
- illegal  output  1  current result came from illegal opcode
- err_sticky  output  1  set on any accepted illegal opcode
- err_clr  input  1  synchronous clear of err_sticky
- op_count  output  CNT_W  number of accepted operations

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, y=0, parity=0, illegal=0, err_sticky=0, op_count=0. in_ready is 1 from the first cycle after release.
- Opcodes:
  - 0 AND: a&b
  - 1 OR: a|b
  - 2 NAND: ~(a&b)
  - 3 NOR: ~(a|b)
  - 4 XOR: a^b
  - 5 XNOR: ~(a^b)
  - 6 NOT: ~a
  - 7 illegal: y=0, illegal=1
- in_ready = !out_valid || out_ready (combinational; single result register; no bubble on back-to-back streaming).
- Accept: in_valid && in_ready at a rising edge.
  - Result loads into y/parity/illegal; out_valid=1 next cycle.
  - Latency exactly 1 cycle.
- Output hold: while out_valid && !out_ready, y/parity/illegal/out_valid hold stable; inputs are not accepted.
- Drain: out_valid && out_ready with no accept in the same cycle -> out_valid=0 next cycle; y holds its last value (don't-care).
- Simultaneous drain and accept: new result loads and out_valid stays 1 (full throughput, one result per cycle).
- in_valid while in_ready=0: no effect. The producer holds a/b/op until accepted.
- op_count increments by 1 per accept and wraps from 2^CNT_W-1 to 0 (no saturation).
- err_sticky:
  - Set on accept with op=7.
  - err_clr clears it.
  - err_clr and an illegal accept in the same cycle: set wins (err_sticky=1).
- parity equals the XOR of all WIDTH bits of the registered y. For an illegal result, parity=0.
- Reset asserted mid-transfer: any pending result is discarded; all outputs return to reset values immediately.
- X on op while in_valid=0 must not propagate to any state.

Test Plan:
- Reset release, no stimulus -> out_valid=0, y=0x00, op_count=0, in_ready=1.
- WIDTH=8, a=0xF0, b=0xCC, out_ready=1, ops 0..6 on consecutive cycles -> y=0xC0,0xFC,0x3F,0x03,0x3C,0xC3,0x0F one cycle after each accept; parity=0,0,0,0,0,0,0; op_count=7.
- Exhaustive 1-bit sweep, WIDTH=1, op=2, (a,b)=00,01,10,11 -> y=1,1,1,0. This regression-checks the original NAND truth table.
- Backpressure: accept op=4 a=0xAA b=0x0F, hold out_ready=0 for 3 cycles while in_valid=1 with new data -> y stays 0xA5, in_ready=0, op_count unchanged. Raise out_ready -> new result appears next cycle.
- op=7 accepted -> y=0x00, illegal=1, err_sticky=1. Later err_clr pulse together with another op=7 accept -> err_sticky stays 1. A lone err_clr -> 0.
- CNT_W=4, 17 accepts -> op_count=1 (wrap). Assert rst_n low while out_valid=1 -> out_valid=0 and op_count=0 immediately.
